// File: rtl/snake_body_writer.sv
// snake_body_writer
// Owns the snake segment list and publishes it as packed coordinate arrays
// for the VGA renderer. Slot 0 is the head; unused slots read as -1.
// Each move computes a candidate head, checks it against the walls, scans the
// body one slot per cycle for a self-hit, then shifts the list (optionally
// growing) or latches game over.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   restart    synchronous re-initialise (highest priority after reset)
//   step       single-cycle move request, honoured only while idle
//   dir        requested direction: 0 up, 1 right, 2 down, 3 left
//   grow       single-cycle pulse, lengthens the snake on the next move
//   x_values   packed x coordinates, slot i at [32*i +: 32]
//   y_values   packed y coordinates, same packing
//   length     number of valid slots
//   game_done  high from a collision until reset or restart
//   busy       high while a move is being evaluated or committed
module snake_body_writer #(
    parameter int MAX_SEGS  = 100,
    parameter int GRID_COLS = 13,
    parameter int GRID_ROWS = 9,
    parameter int INIT_LEN  = 2,
    parameter int INIT_X    = 2,
    parameter int INIT_Y    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     restart,
    input  logic                     step,
    input  logic [1:0]               dir,
    input  logic                     grow,
    output logic [32*MAX_SEGS-1:0]   x_values,
    output logic [32*MAX_SEGS-1:0]   y_values,
    output logic [31:0]              length,
    output logic                     game_done,
    output logic                     busy
);

    localparam int IDX_W = $clog2(MAX_SEGS);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC   = 3'd1,
        ST_SCAN   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t             state_r;
    logic [31:0]        x_r [MAX_SEGS];
    logic [31:0]        y_r [MAX_SEGS];
    logic [31:0]        length_r;
    logic [1:0]         cur_dir_r;
    logic [1:0]         next_dir_r;
    logic [1:0]         mv_dir_r;
    logic               grow_pending_r;
    logic               grow_take_r;   // pending grow consumed by this move
    logic               grow_move_r;   // this move actually lengthens the snake
    logic               game_done_r;
    logic               busy_r;
    logic [31:0]        nh_x_r;
    logic [31:0]        nh_y_r;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   last_r;

    logic signed [31:0] nh_x_s;
    logic signed [31:0] nh_y_s;
    logic               wall_s;
    logic [31:0]        cnt_s;
    logic               hit_s;

    // Candidate head cell for the latched direction and its wall test.
    always_comb begin
        nh_x_s = $signed(x_r[0]);
        nh_y_s = $signed(y_r[0]);
        case (next_dir_r)
            DIR_UP:    nh_y_s = $signed(y_r[0]) - 32'sd1;
            DIR_RIGHT: nh_x_s = $signed(x_r[0]) + 32'sd1;
            DIR_DOWN:  nh_y_s = $signed(y_r[0]) + 32'sd1;
            DIR_LEFT:  nh_x_s = $signed(x_r[0]) - 32'sd1;
            default:   nh_x_s = $signed(x_r[0]);
        endcase
        if ((nh_x_s < 32'sd0) || (nh_x_s >= 32'(GRID_COLS)) ||
            (nh_y_s < 32'sd0) || (nh_y_s >= 32'(GRID_ROWS))) begin
            wall_s = 1'b1;
        end else begin
            wall_s = 1'b0;
        end
    end

    // Number of body slots to compare: the tail is skipped when it will vacate.
    always_comb begin
        if (!grow_pending_r || (length_r == 32'(MAX_SEGS))) begin
            cnt_s = length_r - 32'd1;
        end else begin
            cnt_s = length_r;
        end
    end

    // Self-collision compare for the slot currently being scanned.
    always_comb begin
        if ((x_r[idx_r] == nh_x_r) && (y_r[idx_r] == nh_y_r)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Move FSM, segment storage and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_SEGS; i++) begin
                if (i < INIT_LEN) begin
                    x_r[i] <= 32'(INIT_X - i);
                    y_r[i] <= 32'(INIT_Y);
                end else begin
                    x_r[i] <= 32'hFFFF_FFFF;
                    y_r[i] <= 32'hFFFF_FFFF;
                end
            end
            state_r        <= ST_IDLE;
            length_r       <= 32'(INIT_LEN);
            cur_dir_r      <= DIR_RIGHT;
            next_dir_r     <= DIR_RIGHT;
            mv_dir_r       <= DIR_RIGHT;
            grow_pending_r <= 1'b0;
            grow_take_r    <= 1'b0;
            grow_move_r    <= 1'b0;
            game_done_r    <= 1'b0;
            busy_r         <= 1'b0;
            nh_x_r         <= 32'd0;
            nh_y_r         <= 32'd0;
            idx_r          <= '0;
            last_r         <= '0;
        end else if (restart) begin
            for (int i = 0; i < MAX_SEGS; i++) begin
                if (i < INIT_LEN) begin
                    x_r[i] <= 32'(INIT_X - i);
                    y_r[i] <= 32'(INIT_Y);
                end else begin
                    x_r[i] <= 32'hFFFF_FFFF;
                    y_r[i] <= 32'hFFFF_FFFF;
                end
            end
            state_r        <= ST_IDLE;
            length_r       <= 32'(INIT_LEN);
            cur_dir_r      <= DIR_RIGHT;
            next_dir_r     <= DIR_RIGHT;
            mv_dir_r       <= DIR_RIGHT;
            grow_pending_r <= 1'b0;
            grow_take_r    <= 1'b0;
            grow_move_r    <= 1'b0;
            game_done_r    <= 1'b0;
            busy_r         <= 1'b0;
            nh_x_r         <= 32'd0;
            nh_y_r         <= 32'd0;
            idx_r          <= '0;
            last_r         <= '0;
        end else begin
            // A reversal onto the neck is dropped; bit 1 flip gives the opposite.
            if (dir != (cur_dir_r ^ 2'b10)) begin
                next_dir_r <= dir;
            end else begin
                next_dir_r <= next_dir_r;
            end
            if (grow && (state_r != ST_DONE)) begin
                grow_pending_r <= 1'b1;
            end else begin
                grow_pending_r <= grow_pending_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (step) begin
                        state_r <= ST_CALC;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    // The move's direction and grow decision are frozen here so
                    // inputs arriving during the scan cannot skew the commit.
                    mv_dir_r    <= next_dir_r;
                    nh_x_r      <= nh_x_s;
                    nh_y_r      <= nh_y_s;
                    grow_take_r <= grow_pending_r;
                    grow_move_r <= grow_pending_r && (length_r < 32'(MAX_SEGS));
                    idx_r       <= '0;
                    last_r      <= IDX_W'(cnt_s - 32'd1);
                    if (wall_s) begin
                        state_r     <= ST_DONE;
                        busy_r      <= 1'b0;
                        game_done_r <= 1'b1;
                    end else if (cnt_s == 32'd0) begin
                        state_r <= ST_COMMIT;
                    end else begin
                        state_r <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (hit_s) begin
                        state_r     <= ST_DONE;
                        busy_r      <= 1'b0;
                        game_done_r <= 1'b1;
                    end else if (idx_r == last_r) begin
                        state_r <= ST_COMMIT;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                ST_COMMIT: begin
                    x_r[0] <= nh_x_r;
                    y_r[0] <= nh_y_r;
                    // After the shift, slot[length] would hold the old tail.
                    for (int i = 1; i < MAX_SEGS; i++) begin
                        if (!grow_move_r && (32'(i) == length_r)) begin
                            x_r[i] <= 32'hFFFF_FFFF;
                            y_r[i] <= 32'hFFFF_FFFF;
                        end else begin
                            x_r[i] <= x_r[i-1];
                            y_r[i] <= y_r[i-1];
                        end
                    end
                    if (grow_move_r) begin
                        length_r <= length_r + 32'd1;
                    end else begin
                        length_r <= length_r;
                    end
                    cur_dir_r      <= mv_dir_r;
                    // A grow pulse that arrived after CALC survives to the next move.
                    grow_pending_r <= grow | (grow_pending_r & ~grow_take_r);
                    state_r        <= ST_IDLE;
                    busy_r         <= 1'b0;
                end
                ST_DONE: begin
                    state_r     <= ST_DONE;
                    game_done_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < MAX_SEGS; g++) begin : g_pack
        assign x_values[32*g +: 32] = x_r[g];
        assign y_values[32*g +: 32] = y_r[g];
    end

    assign length    = length_r;
    assign game_done = game_done_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_snake_body_writer.sv
module tb_snake_body_writer;

    localparam int MAX_SEGS = 100;
    localparam logic [31:0] NEG1 = 32'hFFFF_FFFF;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   restart;
    logic                   step;
    logic [1:0]             dir;
    logic                   grow;
    logic [32*MAX_SEGS-1:0] x_values;
    logic [32*MAX_SEGS-1:0] y_values;
    logic [31:0]            length;
    logic                   game_done;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snake_body_writer dut (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .step      (step),
        .dir       (dir),
        .grow      (grow),
        .x_values  (x_values),
        .y_values  (y_values),
        .length    (length),
        .game_done (game_done),
        .busy      (busy)
    );

    typedef struct {
        logic [1:0]  d;
        logic        g;
        logic [31:0] hx;
        logic [31:0] hy;
        logic [31:0] s1x;
        logic [31:0] s1y;
        logic [31:0] len;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [31:0] sx(input int i);
        return x_values[32*i +: 32];
    endfunction

    function automatic logic [31:0] sy(input int i);
        return y_values[32*i +: 32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_init(input string p);
        check({p, "_s0x"}, sx(0), 32'd2);
        check({p, "_s0y"}, sy(0), 32'd4);
        check({p, "_s1x"}, sx(1), 32'd1);
        check({p, "_s1y"}, sy(1), 32'd4);
        check({p, "_s2x"}, sx(2), NEG1);
        check({p, "_s3y"}, sy(3), NEG1);
        check({p, "_s4x"}, sx(4), NEG1);
        check({p, "_len"}, length, 32'd2);
        check({p, "_busy"}, {31'd0, busy}, 32'd0);
        check({p, "_done"}, {31'd0, game_done}, 32'd0);
    endtask

    // Returns at the first falling edge after step was sampled.
    task automatic pulse_step(input logic [1:0] d, input logic g);
        @(negedge clk);
        dir  = d;
        grow = g;
        @(negedge clk);
        grow = 1'b0;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset   = 1'b1;
        restart = 1'b0;
        step    = 1'b0;
        grow    = 1'b0;
        dir     = 2'd1;

        vecs[0] = '{2'd1, 1'b0, 32'd3, 32'd4, 32'd2, 32'd4, 32'd2};
        vecs[1] = '{2'd1, 1'b1, 32'd4, 32'd4, 32'd3, 32'd4, 32'd3};
        vecs[2] = '{2'd3, 1'b0, 32'd5, 32'd4, 32'd4, 32'd4, 32'd3};
        vecs[3] = '{2'd2, 1'b0, 32'd5, 32'd5, 32'd5, 32'd4, 32'd3};
        vecs[4] = '{2'd0, 1'b0, 32'd5, 32'd6, 32'd5, 32'd5, 32'd3};
        vecs[5] = '{2'd3, 1'b0, 32'd4, 32'd6, 32'd5, 32'd6, 32'd3};
        vecs[6] = '{2'd0, 1'b0, 32'd4, 32'd5, 32'd4, 32'd6, 32'd3};

        #1 reset = 1'b0;
        #11;
        check_init("rst_low");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_init("rst_rel");

        // Single move right: busy lasts exactly three cycles.
        pulse_step(2'd1, 1'b0);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, 32'd3);
        check("mv1_s0x", sx(0), 32'd3);
        check("mv1_s1x", sx(1), 32'd2);
        check("mv1_s2x", sx(2), NEG1);
        check("mv1_len", length, 32'd2);

        // Table of moves from the init state.
        do_reset();
        for (int v = 0; v < 7; v++) begin
            pulse_step(vecs[v].d, vecs[v].g);
            wait_idle(n);
            check($sformatf("v%0d_hx", v), sx(0), vecs[v].hx);
            check($sformatf("v%0d_hy", v), sy(0), vecs[v].hy);
            check($sformatf("v%0d_s1x", v), sx(1), vecs[v].s1x);
            check($sformatf("v%0d_s1y", v), sy(1), vecs[v].s1y);
            check($sformatf("v%0d_len", v), length, vecs[v].len);
            check($sformatf("v%0d_tail", v), sx(int'(vecs[v].len)), NEG1);
            check($sformatf("v%0d_done", v), {31'd0, game_done}, 32'd0);
        end

        // Right wall: ten moves reach x=12, the eleventh fails.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            pulse_step(2'd1, 1'b0);
            wait_idle(n);
        end
        check("wall_pre_hx", sx(0), 32'd12);
        pulse_step(2'd1, 1'b0);
        check("wall_k_busy", {31'd0, busy}, 32'd1);
        check("wall_k_done", {31'd0, game_done}, 32'd0);
        @(negedge clk);
        check("wall_done", {31'd0, game_done}, 32'd1);
        check("wall_busy", {31'd0, busy}, 32'd0);
        check("wall_hx", sx(0), 32'd12);
        check("wall_hy", sy(0), 32'd4);
        check("wall_s1x", sx(1), 32'd11);
        pulse_step(2'd2, 1'b1);
        repeat (4) @(negedge clk);
        check("wall_frz_hx", sx(0), 32'd12);
        check("wall_frz_hy", sy(0), 32'd4);
        check("wall_frz_len", length, 32'd2);
        check("wall_frz_done", {31'd0, game_done}, 32'd1);
        check("wall_frz_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check_init("rs_done");

        // Self-hit: length 5 heading right, then down, left, up.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pulse_step(2'd1, 1'b1);
            wait_idle(n);
        end
        check("sh_len5", length, 32'd5);
        check("sh_hx5", sx(0), 32'd5);
        check("sh_s4x", sx(4), 32'd1);
        pulse_step(2'd2, 1'b0);
        wait_idle(n);
        pulse_step(2'd3, 1'b0);
        wait_idle(n);
        check("sh_pre_hx", sx(0), 32'd4);
        check("sh_pre_hy", sy(0), 32'd5);
        pulse_step(2'd0, 1'b0);
        wait_idle(n);
        check("sh_cycles", n, 32'd5);
        check("sh_done", {31'd0, game_done}, 32'd1);
        check("sh_hx", sx(0), 32'd4);
        check("sh_hy", sy(0), 32'd5);
        check("sh_s3x", sx(3), 32'd4);
        check("sh_s3y", sy(3), 32'd4);
        check("sh_s4x", sx(4), 32'd3);
        check("sh_s5x", sx(5), NEG1);
        check("sh_len", length, 32'd5);

        // Restart while scanning a length-5 body.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pulse_step(2'd1, 1'b1);
            wait_idle(n);
        end
        pulse_step(2'd1, 1'b0);
        @(negedge clk);
        check("rs_scan_busy", {31'd0, busy}, 32'd1);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check_init("rs_scan");
        repeat (6) @(negedge clk);
        check("rs_scan_hold", sx(0), 32'd2);

        // Asynchronous reset while in COMMIT.
        pulse_step(2'd1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("ar_busy", {31'd0, busy}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check_init("ar_now");
        @(posedge clk);
        #1;
        check_init("ar_hold");
        @(negedge clk);
        reset = 1'b1;
        pulse_step(2'd1, 1'b0);
        wait_idle(n);
        check("ar_after_hx", sx(0), 32'd3);
        check("ar_after_len", length, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_body_writer.md
# snake_body_writer

Owns the snake's segment list and produces the packed `x_values`/`y_values` arrays that the VGA renderer reads. Slot 0 is the head, and unused slots hold -1 (32'hFFFF_FFFF). On each game tick it does four things: computes the next head cell from the current direction, checks it against the walls and the snake's own body with a sequential scan, then commits a one-slot shift (with optional growth) or flags game over. It sits between the game-tick/keyboard logic and the VGA controller.

## Interface
- `MAX_SEGS`, 100: number of slots; the arrays are `32*MAX_SEGS` bits wide.
- `GRID_COLS`, 13: board width in tiles; legal x is 0..GRID_COLS-1.
- `GRID_ROWS`, 9: board height in tiles; legal y is 0..GRID_ROWS-1.
- `INIT_LEN`, 2: length after reset or restart.
- `INIT_X`, 2: head x after reset or restart; the body extends leftward (x-1, x-2, …).
- `INIT_Y`, 4: head y after reset or restart.

Ports (name, direction, width, meaning):
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `restart` in 1: synchronous re-initialise; highest priority.
- `step` in 1: single-cycle move tick.
- `dir` in 2: requested direction (0 up / y-1, 1 right / x+1, 2 down / y+1, 3 left / x-1).
- `grow` in 1: single-cycle pulse; the next committed move lengthens the snake.
- `x_values` out 32*MAX_SEGS: slot i is at `[32*i +: 32]`; registered.
- `y_values` out 32*MAX_SEGS: same packing as `x_values`.
- `length` out 32: number of valid slots.
- `game_done` out 1: high from a collision until reset or restart.
- `busy` out 1: high whenever the state is not IDLE or DONE.

## Operation
- States are IDLE, CALC, SCAN, COMMIT and DONE.
- Init values (on reset or restart):
  - slots 0..INIT_LEN-1 = (INIT_X-i, INIT_Y);
  - all other slots = -1;
  - `length`=INIT_LEN, current direction = right;
  - `grow_pending`=0, `game_done`=0, `busy`=0;
  - state = IDLE.
- Direction latch:
  - In any state, `dir` is copied to `next_dir` each cycle unless it is the exact opposite of the current committed direction; opposite requests are dropped.
  - The current direction updates from `next_dir` at COMMIT.
- `grow` sets `grow_pending` in any state except DONE. It is cleared at COMMIT.
- IDLE:
  - `step` goes to CALC.
  - `step` is ignored in every other state; there is no queuing.
- CALC (1 cycle):
  - Compute `nh` = head moved in the `next_dir` direction, using signed arithmetic.
  - If `nh` x<0, x≥GRID_COLS, y<0 or y≥GRID_ROWS, go to DONE.
  - Otherwise set the compare count N:
    - N = length-1 if `grow_pending` is clear or length==MAX_SEGS, since the tail vacates its cell;
    - N = length otherwise.
  - Go to SCAN with index 0, or straight to COMMIT if N==0.
- SCAN:
  - Compare one slot per cycle against `nh`.
  - On a match, go to DONE.
  - If the index reaches N-1 without a match, go to COMMIT.
- COMMIT (1 cycle):
  - Slot i+1 ← slot i for all i < MAX_SEGS-1, and slot 0 ← `nh`.
  - If growing (`grow_pending` set and length<MAX_SEGS): length+1.
  - Otherwise: slot[length] ← -1 (the old tail is dropped) and length is unchanged.
  - Clear `grow_pending`, then go to IDLE.
  - At length==MAX_SEGS, `grow` is absorbed: length saturates and the arrays shift with no growth.
- DONE:
  - `game_done`=1.
  - The arrays and length are frozen at their pre-step values; a failed move never writes the arrays.
  - `step` and `grow` are ignored.
  - The block leaves DONE only via reset or restart.
- Priority is reset > restart > everything else. A restart arriving mid-SCAN abandons the move without any partial commit.

## Timing
- `step` is sampled high in IDLE at edge k.
- CALC result lands at edge k+1:
  - on a wall hit, `game_done` is visible after edge k+1;
  - otherwise `busy` is high from after edge k to after edge k+N+2.
- A self-hit at index j sets `game_done` after edge k+2+j.
- A successful move shows updated arrays and length after edge k+N+2; `busy` drops in the same cycle.
- `restart` sampled at edge m: init values are visible after edge m.
- `reset` low forces init values immediately, without waiting for a clock edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then one `step` with `dir`=1:
  - slot0=(3,4), slot1=(2,4), slot2=-1;
  - `length`=2, `game_done`=0;
  - `busy` high exactly 3 cycles (N=1).
- `grow` pulse, then `step` right from the init state:
  - `length`=3;
  - slots (3,4),(2,4),(1,4);
  - slot3=-1.
- `dir`=3 while moving right, then `step`:
  - the reversal is ignored;
  - head becomes (3,4).
- Step right 10 times from init (head at x=12), then an 11th step:
  - `game_done`=1 two cycles after that step;
  - arrays still show head (12,4);
  - later `step` pulses change nothing.
- Grow to length 5 with head at (5,4) moving right, then step down, left, up:
  - the third move's `nh`=(4,4) matches slot 3;
  - `game_done`=1;
  - arrays unchanged.
- `restart` pulse during SCAN of a length-5 snake:
  - the next cycle shows init values;
  - `busy`=0, `game_done`=0, no partial shift.
- Drive `reset` low asynchronously mid-COMMIT: outputs hold init values while `reset` is low.
